// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 1011 sequence detector slice.
// FSM state encoding, pattern value and result counter width.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         CNT_W   = 4;

endpackage

// File: rtl/seq_detect_1011_core.sv
// Bit-serial 1011 detector with a registered 3-bit history.
// Ports: clk, reset (sync, active-low), clear, bit_valid, bit_in, match.
module seq_detect_1011_core
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match
);

  logic [2:0] hist;
  logic [1:0] fill;

  // fill saturates at 3: a match needs three prior bits of this word
  assign match = bit_valid
              && (fill == 2'd3)
              && ({hist, bit_in} == PATTERN);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= {hist[1:0], bit_in};
      if (fill != 2'd3)
        fill <= fill + 2'd1;
    end
  end

endmodule

// File: rtl/seq_detect_arb.sv
// Round-robin two-requester arbiter feeding words MSB-first into a
// 1011 detector. Ports: clk, reset, req, data0/1, gnt, busy, done, res_*.
module seq_detect_arb
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              res_id,
  output logic [3:0]        res_cnt,
  output logic              res_hit,
  output logic [3:0]        res_first
);

  localparam logic [3:0] LAST = 4'(DATA_W - 1);

  state_t            state;
  logic              last_id;
  logic              cur_id;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        bit_idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  first;
  logic [CNT_W-1:0]  cnt_nx;
  logic [CNT_W-1:0]  first_nx;
  logic              pick;
  logic              take;
  logic              match;

  // grant is decided in the IDLE cycle itself so data is
  // sampled on the same edge that leaves IDLE
  assign pick = (req == 2'b11) ? ~last_id : req[1];
  assign take = reset && (state == IDLE) && (req != 2'b00);
  assign gnt  = take ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != IDLE) || take;

  assign cnt_nx   = cnt + CNT_W'(match);
  assign first_nx = (match && cnt == '0) ? bit_idx : first;

  seq_detect_1011_core u_core (
    .clk       (clk),
    .reset     (reset),
    .clear     (take),
    .bit_valid (state == SHIFT),
    .bit_in    (shift_reg[DATA_W-1]),
    .match     (match)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      cur_id    <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      first     <= '0;
      done      <= 1'b0;
      res_id    <= 1'b0;
      res_cnt   <= '0;
      res_hit   <= 1'b0;
      res_first <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            shift_reg <= pick ? data1 : data0;
            cur_id    <= pick;
            last_id   <= pick;
            bit_idx   <= '0;
            cnt       <= '0;
            first     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          bit_idx   <= bit_idx + 4'd1;
          cnt       <= cnt_nx;
          first     <= first_nx;
          if (bit_idx == LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            res_id    <= cur_id;
            res_cnt   <= cnt_nx;
            res_hit   <= (cnt_nx != '0);
            res_first <= first_nx;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_arb.sv
// Self-checking bench for seq_detect_arb (DATA_W=8 and DATA_W=16).
// Directed words with literal results plus a per-cycle reference model.
module tb_seq_detect_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [1:0]  gnt;
  logic        busy;
  logic        done;
  logic        res_id;
  logic [3:0]  res_cnt;
  logic        res_hit;
  logic [3:0]  res_first;

  logic [1:0]  req16;
  logic [15:0] d16;
  logic [1:0]  gnt16;
  logic        busy16;
  logic        done16;
  logic        id16;
  logic [3:0]  cnt16;
  logic        hit16;
  logic [3:0]  first16;

  int n_cmp = 0;
  int n_err = 0;
  bit run   = 0;

  seq_detect_arb #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .res_id    (res_id),
    .res_cnt   (res_cnt),
    .res_hit   (res_hit),
    .res_first (res_first)
  );

  seq_detect_arb #(.DATA_W(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .req       (req16),
    .data0     (d16),
    .data1     (16'h0000),
    .gnt       (gnt16),
    .busy      (busy16),
    .done      (done16),
    .res_id    (id16),
    .res_cnt   (cnt16),
    .res_hit   (hit16),
    .res_first (first16)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slide a 4-bit window over the word in shift order (MSB first)
  function automatic void ref_word(input logic [15:0] w,
                                   input int nb,
                                   output int c,
                                   output int f);
    c = 0;
    f = 0;
    for (int i = 3; i < nb; i++) begin
      int win;
      win = 0;
      for (int k = i - 3; k <= i; k++)
        win = win * 2 + int'(w[nb-1-k]);
      if (win == 11) begin
        if (c == 0) f = i;
        c++;
      end
    end
  endfunction

  // Reference model: word occupies DATA_W+2 cycles from grant
  int   m_left = 0;
  logic m_last = 1'b1;
  logic m_id   = 1'b0;
  int   m_cnt  = 0;
  int   m_first = 0;

  initial begin
    forever begin
      logic [1:0] eg;
      logic       id;
      @(negedge clk);
      eg = 2'b00;
      id = 1'b0;
      if (m_left == 0 && reset && req != 2'b00) begin
        id = (req == 2'b11) ? !m_last : req[1];
        eg = id ? 2'b10 : 2'b01;
      end
      if (run) begin
        chk("m_gnt", gnt, eg);
        chk("m_busy", busy, (m_left > 0 || eg != 0));
        chk("m_done", done, (m_left == 1));
        if (m_left == 1 && done) begin
          chk("m_id", res_id, m_id);
          chk("m_cnt", res_cnt, m_cnt);
          chk("m_hit", res_hit, (m_cnt != 0));
          chk("m_first", res_first, m_first);
        end
      end
      if (!reset) begin
        m_left = 0;
        m_last = 1'b1;
      end else if (eg != 2'b00) begin
        m_left = 9;
        m_id   = id;
        m_last = id;
        ref_word({8'h00, id ? data1 : data0}, 8, m_cnt, m_first);
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic word(input logic [1:0] rq,
                      input logic [7:0] d0,
                      input logic [7:0] d1,
                      input logic [1:0] eg,
                      input int ecnt,
                      input int efirst,
                      input logic eid);
    int n;
    @(posedge clk);
    #1 req = rq;
    data0 = d0;
    data1 = d1;
    @(negedge clk);
    chk("gnt", gnt, eg);
    @(posedge clk);
    #1 req = rq & ~eg;
    if (eg[0]) data0 = ~d0;
    else data1 = ~d1;
    wait_done(n);
    chk("latency", n, 9);
    chk("res_id", res_id, eid);
    chk("res_cnt", res_cnt, ecnt);
    chk("res_hit", res_hit, (ecnt != 0));
    chk("res_first", res_first, efirst);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    int c;
    int f;
    int n;
    bit seen;
    reset = 0;
    req   = 0;
    data0 = 0;
    data1 = 0;
    req16 = 0;
    d16   = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    run = 1;
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", res_id, 0);
    chk("rst_cnt", res_cnt, 0);
    chk("rst_hit", res_hit, 0);
    chk("rst_first", res_first, 0);
    chk("rst_busy16", busy16, 0);

    ref_word(16'h00B6, 8, c, f);
    chk("pin8_cnt", c, 2);
    chk("pin8_first", f, 3);
    ref_word(16'hB6DB, 16, c, f);
    chk("pin16_cnt", c, 5);
    chk("pin16_first", f, 3);

    word(2'b01, 8'b10110110, 8'h00, 2'b01, 2, 3, 1'b0);
    word(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 1'b0);
    word(2'b01, 8'hFF, 8'h00, 2'b01, 0, 0, 1'b0);

    do_reset();
    word(2'b11, 8'h0B, 8'hB0, 2'b01, 1, 7, 1'b0);
    word(2'b10, 8'h0B, 8'hB0, 2'b10, 1, 3, 1'b1);

    word(2'b01, 8'b00000101, 8'h00, 2'b01, 0, 0, 1'b0);
    word(2'b01, 8'b10000000, 8'h00, 2'b01, 0, 0, 1'b0);

    // abort a word with reset asserted in its fourth shift cycle
    @(posedge clk);
    #1 req = 2'b01;
    data0 = 8'hB6;
    @(negedge clk);
    chk("ab_gnt", gnt, 2'b01);
    @(posedge clk);
    #1 req = 2'b00;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_gnt0", gnt, 2'b00);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("ab_nodone", seen, 0);
    word(2'b11, 8'h0B, 8'hB0, 2'b01, 1, 7, 1'b0);
    word(2'b10, 8'h0B, 8'hB0, 2'b10, 1, 3, 1'b1);
    word(2'b10, 8'h00, 8'h0B, 2'b10, 1, 7, 1'b1);

    @(posedge clk);
    #1 req16 = 2'b01;
    d16 = 16'b1011011011011011;
    @(negedge clk);
    chk("w16_gnt", gnt16, 2'b01);
    @(posedge clk);
    #1 req16 = 2'b00;
    d16 = 16'h0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 40);
    chk("w16_lat", n, 17);
    chk("w16_id", id16, 0);
    chk("w16_cnt", cnt16, 5);
    chk("w16_hit", hit16, 1);
    chk("w16_first", first16, 3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
